// File: rtl/riscv_mc_ctrl.sv
// riscv_mc_ctrl: multicycle RV32I control FSM over a shared req/ready memory port.
// Optional bus watchdog enabled by defining MC_CTRL_WATCHDOG_EN.
module riscv_mc_ctrl #(
    parameter int MEM_TIMEOUT     = 16,
    parameter int CNT_W           = 5,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       btaken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic [2:0] imm_src,
    output logic       reg_write,
    output logic       illegal,
    output logic       bus_err,
    output logic [3:0] state_o
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
        MEMWR = 4'd5, EXR = 4'd6, EXI = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9,
        JAL = 4'd10, JALR = 4'd11, LINK = 4'd12, UPPER = 4'd13, TRAP = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    state_t state, nxt;
    logic   is_store, is_lui, timeout;

    // Next state; the opcode is only consulted in DECODE, later states use the captured flags
    always_comb begin
        nxt = state;
        case (state)
            FETCH:  nxt = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: nxt = MEMADR;
                    OP_R:              nxt = EXR;
                    OP_I:              nxt = EXI;
                    OP_BR:             nxt = BRANCH;
                    OP_JAL:            nxt = JAL;
                    OP_JALR:           nxt = JALR;
                    OP_LUI, OP_AUIPC:  nxt = UPPER;
                    default:           nxt = TRAP_ON_ILLEGAL ? TRAP : FETCH;
                endcase
            end
            MEMADR: nxt = is_store ? MEMWR : MEMRD;
            MEMRD:  nxt = mem_ready ? MEMWB : MEMRD;
            MEMWR:  nxt = mem_ready ? FETCH : MEMWR;
            MEMWB, ALUWB, BRANCH:   nxt = FETCH;
            EXR, EXI, LINK, UPPER:  nxt = ALUWB;
            JAL, JALR:              nxt = LINK;
            TRAP:   nxt = TRAP;
            default: nxt = TRAP;
        endcase
        if (timeout) nxt = TRAP;
    end

    // State register; load/store and LUI/AUIPC distinctions are latched while IR is decoded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            is_store <= 1'b0;
            is_lui   <= 1'b0;
        end else begin
            state <= nxt;
            if (state == DECODE) begin
                is_store <= (opcode == OP_STORE);
                is_lui   <= (opcode == OP_LUI);
            end
        end
    end

`ifdef MC_CTRL_WATCHDOG_EN
    logic [CNT_W-1:0] cnt;
    logic             err;

    assign timeout = mem_req && (cnt == CNT_W'(MEM_TIMEOUT));
    assign bus_err = err;

    // Watchdog restarts on entry to each request state and counts stalled request cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            if (nxt != state && (nxt == FETCH || nxt == MEMRD || nxt == MEMWR)) cnt <= '0;
            else if (mem_req && !mem_ready) cnt <= cnt + 1'b1;
            if (timeout) err <= 1'b1;
        end
    end
`else
    localparam int unused_cfg = MEM_TIMEOUT + CNT_W;
    assign timeout = 1'b0;
    assign bus_err = 1'b0;
`endif

    // Moore datapath controls; only the FETCH latches and the branch PC load follow inputs
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        case (state)
            FETCH: begin
                mem_req    = 1'b1;
                ir_write   = mem_ready && !timeout;
                pc_write   = mem_ready && !timeout;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMRD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = 1'b1;
            end
            EXR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            EXI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b11;
            end
            ALUWB: reg_write = 1'b1;
            BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_write  = btaken;
            end
            JAL: pc_write = 1'b1;
            JALR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = 1'b1;
            end
            LINK: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            UPPER: begin
                alu_src_a = is_lui ? 2'b11 : 2'b01;
                alu_src_b = 2'b01;
            end
            TRAP: illegal = 1'b1;
            default: ;
        endcase
    end

    // Immediate format follows the IR opcode in every state
    always_comb begin
        imm_src = 3'b000;
        case (opcode)
            OP_STORE:         imm_src = 3'b001;
            OP_BR:            imm_src = 3'b010;
            OP_JAL:           imm_src = 3'b011;
            OP_LUI, OP_AUIPC: imm_src = 3'b100;
            default:          ;
        endcase
    end

    assign state_o = state;
endmodule
